// File: rtl/spi_boot_loader_pkg.sv
// Shared constants and state encoding for the SPI boot loader.
// SPI READ frame layout, word width and loader FSM states.
package spi_boot_loader_pkg;

  localparam logic [7:0]  SPI_CMD_READ     = 8'h03;
  localparam logic [15:0] EEPROM_BOOT_ADDR = 16'h0000;
  localparam int          SPI_CMD_BITS     = 24;
  localparam int          BOOT_WORD_BITS   = 16;
  localparam int          SHIFT_LEN_W      = 5;

  // Full READ frame shifted out MSB first: command byte then 16-bit address.
  localparam logic [SPI_CMD_BITS-1:0] READ_FRAME = {SPI_CMD_READ, EEPROM_BOOT_ADDR};

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
    WRITE,
    DONE
  } loaderState_t;

endpackage

// File: rtl/spi_boot_loader_shifter.sv
// SPI mode-0 bit engine for the boot loader.
// CLK_DIV sysclk cycles per SCLK half-period; each bit is a low phase
// (MOSI valid) followed by a high phase. MISO is captured on the edge that
// raises SCLK. o_lastEdge flags the edge ending the final high phase so the
// caller can chain the next transfer on that same edge. i_hold freezes the
// engine with SCLK low.
module spi_boot_loader_shifter
  import spi_boot_loader_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_load,
  input  logic [SHIFT_LEN_W-1:0]  i_len,
  input  logic [SPI_CMD_BITS-1:0] i_txWord,
  input  logic                    i_hold,
  input  logic                    i_miso,
  output logic                    o_sclk,
  output logic                    o_mosi,
  output logic                    o_lastEdge,
  output logic [BOOT_WORD_BITS-1:0] o_rxWord
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]          divCnt;
  logic [SHIFT_LEN_W-1:0]    bitsLeft;
  logic                      active;
  logic [SPI_CMD_BITS-1:0]   txShift;
  logic [BOOT_WORD_BITS-1:0] rxShift;
  logic                      phaseEnd;

  assign phaseEnd   = active && !i_hold && (divCnt == DIV_LAST);
  assign o_lastEdge = phaseEnd && o_sclk && (bitsLeft == SHIFT_LEN_W'(1));
  assign o_rxWord   = rxShift;

  // Divider, bit counter and shift registers; a load restarts a transfer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: registers use non-blocking assignments so every branch reads pre-edge values.
    if (i_rst) begin
      divCnt   <= '0;
      bitsLeft <= '0;
      active   <= 1'b0;
      txShift  <= '0;
      rxShift  <= '0;
      o_sclk   <= 1'b0;
      o_mosi   <= 1'b0;
    end else if (i_load) begin
      active   <= 1'b1;
      divCnt   <= '0;
      bitsLeft <= i_len;
      o_mosi   <= i_txWord[SPI_CMD_BITS-1];
      txShift  <= {i_txWord[SPI_CMD_BITS-2:0], 1'b0};
      o_sclk   <= 1'b0;
    end else if (active && !i_hold) begin
      if (phaseEnd) begin
        divCnt <= '0;
        if (!o_sclk) begin
          o_sclk  <= 1'b1;
          rxShift <= {rxShift[BOOT_WORD_BITS-2:0], i_miso};
        end else begin
          o_sclk   <= 1'b0;
          bitsLeft <= bitsLeft - SHIFT_LEN_W'(1);
          if (bitsLeft == SHIFT_LEN_W'(1)) begin
            active <= 1'b0;
            o_mosi <= 1'b0;
          end else begin
            o_mosi  <= txShift[SPI_CMD_BITS-1];
            txShift <= {txShift[SPI_CMD_BITS-2:0], 1'b0};
          end
        end
      end else begin
        divCnt <= divCnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/spi_boot_loader.sv
// Boot-time image loader: SPI EEPROM (READ 0x03 from 0x0000) -> parallel SRAM.
// Copies LOAD_WORDS 16-bit words to SRAM addresses 0..LOAD_WORDS-1, one
// single-cycle write strobe per word, holding SCLK low during each write.
// Optional feature macro BOOT_LOADER_CHECKSUM_EN adds o_csumOk, high in DONE
// when the mod-2^16 sum of all loaded words is zero.
module spi_boot_loader
  import spi_boot_loader_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int LOAD_WORDS = 32768
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_spiMISO,
  output logic        o_spiMOSI,
  output logic        o_spiCLK,
  output logic        o_spiCSn,
  output logic [15:0] o_memAddr,
  output logic [15:0] o_memData,
  output logic        o_memEn,
  output logic        o_memWr,
  output logic        o_busy,
  output logic        o_done
`ifdef BOOT_LOADER_CHECKSUM_EN
  ,
  output logic        o_csumOk
`endif
);

  generate
    if (LOAD_WORDS < 1 || LOAD_WORDS > 32768) begin : gLoadWordsRange
      $error("spi_boot_loader: LOAD_WORDS must be in 1..32768");
    end
    if (CLK_DIV < 1) begin : gClkDivRange
      $error("spi_boot_loader: CLK_DIV must be >= 1");
    end
  endgenerate

  localparam logic [15:0] LAST_WORD = 16'(LOAD_WORDS - 1);

  loaderState_t            state;
  logic [15:0]             wordCnt;
  logic                    startOk;
  logic                    shLoad;
  logic [SHIFT_LEN_W-1:0]  shLen;
  logic [SPI_CMD_BITS-1:0] shTx;
  logic                    shLast;
  logic [BOOT_WORD_BITS-1:0] rxWord;

  assign startOk = i_start && (state == IDLE || state == DONE);

  spi_boot_loader_shifter #(
    .CLK_DIV (CLK_DIV)
  ) uShifter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (shLoad),
    .i_len      (shLen),
    .i_txWord   (shTx),
    .i_hold     (state == WRITE),
    .i_miso     (i_spiMISO),
    .o_sclk     (o_spiCLK),
    .o_mosi     (o_spiMOSI),
    .o_lastEdge (shLast),
    .o_rxWord   (rxWord)
  );

  // Shifter load requests, issued on the same edge as the FSM transition.
  always_comb begin
    // NOTE: defaults first so every path assigns every output (no inferred latch).
    shLoad = 1'b0;
    shLen  = SHIFT_LEN_W'(BOOT_WORD_BITS);
    shTx   = '0;
    if (startOk) begin
      shLoad = 1'b1;
      shLen  = SHIFT_LEN_W'(SPI_CMD_BITS);
      shTx   = READ_FRAME;
    end else if (state == CMD && shLast) begin
      shLoad = 1'b1;
    end else if (state == WRITE && wordCnt != LAST_WORD) begin
      shLoad = 1'b1;
    end
  end

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [15:0] csum;
  logic [15:0] csumNext;
  assign csumNext = csum + o_memData;
`endif

  // Loader FSM with word counter and registered SRAM/SPI control outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      wordCnt   <= '0;
      o_spiCSn  <= 1'b1;
      o_memAddr <= '0;
      o_memData <= '0;
      o_memEn   <= 1'b0;
      o_memWr   <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      csum      <= '0;
      o_csumOk  <= 1'b0;
`endif
    end else begin
      o_memEn <= 1'b0;
      o_memWr <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (i_start) begin
            state    <= CMD;
            wordCnt  <= '0;
            o_spiCSn <= 1'b0;
            o_busy   <= 1'b1;
            o_done   <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum     <= '0;
            o_csumOk <= 1'b0;
`endif
          end
        end
        CMD: begin
          if (shLast) state <= DATA;
        end
        DATA: begin
          if (shLast) begin
            state     <= WRITE;
            o_memEn   <= 1'b1;
            o_memWr   <= 1'b1;
            o_memData <= rxWord;
            o_memAddr <= wordCnt;
          end
        end
        WRITE: begin
`ifdef BOOT_LOADER_CHECKSUM_EN
          csum <= csumNext;
`endif
          if (wordCnt == LAST_WORD) begin
            state    <= DONE;
            o_spiCSn <= 1'b1;
            o_busy   <= 1'b0;
            o_done   <= 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
            o_csumOk <= (csumNext == 16'h0000);
`endif
          end else begin
            state   <= DATA;
            wordCnt <= wordCnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_boot_loader.sv
// Self-checking bench for spi_boot_loader: behavioural mode-0 EEPROM with
// auto-increment plus an SRAM write monitor. Expected writes and strobe
// timing come from the image bytes and the documented latency formula.
// Define BOOT_LOADER_CHECKSUM_EN to also exercise o_csumOk.
module tb_spi_boot_loader;

  localparam int CLK_DIV    = 2;
  localparam int LOAD_WORDS = 4;
  localparam int FIRST_LAT  = 1 + 40 * 2 * CLK_DIV;
  localparam int WORD_LAT   = 32 * CLK_DIV + 1;
  localparam int LOAD_BUDGET = FIRST_LAT + LOAD_WORDS * WORD_LAT + 50;
  localparam int EE_SIZE    = 16;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_spiMISO = 1'b0;
  logic        o_spiMOSI;
  logic        o_spiCLK;
  logic        o_spiCSn;
  logic [15:0] o_memAddr;
  logic [15:0] o_memData;
  logic        o_memEn;
  logic        o_memWr;
  logic        o_busy;
  logic        o_done;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic        o_csumOk;
`endif

  spi_boot_loader #(
    .CLK_DIV    (CLK_DIV),
    .LOAD_WORDS (LOAD_WORDS)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_spiMISO (i_spiMISO),
    .o_spiMOSI (o_spiMOSI),
    .o_spiCLK  (o_spiCLK),
    .o_spiCSn  (o_spiCSn),
    .o_memAddr (o_memAddr),
    .o_memData (o_memData),
    .o_memEn   (o_memEn),
    .o_memWr   (o_memWr),
    .o_busy    (o_busy),
    .o_done    (o_done)
`ifdef BOOT_LOADER_CHECKSUM_EN
    ,
    .o_csumOk  (o_csumOk)
`endif
  );

  always #5 i_clk = ~i_clk;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int startCyc = 0;

  // Rising-edge index, used to time write strobes relative to the start pulse.
  always @(posedge i_clk) cycle++;

  logic [7:0]  eeprom [0:EE_SIZE-1];
  logic        prevSclk = 1'b0;
  int          bitCnt = 0;
  int          dbit = 0;
  logic [23:0] cmdSr = '0;
  int          dataMosiOnes = 0;
  int          cmdQ[$];
  int          wrAddrQ[$];
  int          wrDataQ[$];
  int          wrWrQ[$];
  int          wrCycQ[$];

  // EEPROM model (mode 0, auto-increment) and SRAM write monitor, sampled mid-cycle.
  always @(negedge i_clk) begin
    if (o_spiCSn) begin
      bitCnt = 0;
      i_spiMISO = 1'b0;
    end else if (o_spiCLK && !prevSclk) begin
      if (bitCnt < 24) begin
        cmdSr = {cmdSr[22:0], o_spiMOSI};
        if (bitCnt == 23) cmdQ.push_back(int'(cmdSr));
      end else if (o_spiMOSI) begin
        dataMosiOnes++;
      end
      bitCnt++;
    end else if (!o_spiCLK && prevSclk && bitCnt >= 24) begin
      dbit = bitCnt - 24;
      i_spiMISO = eeprom[(int'(cmdSr[15:0]) + dbit / 8) % EE_SIZE][7 - (dbit % 8)];
    end
    prevSclk = o_spiCLK;
    if (o_memEn) begin
      wrAddrQ.push_back(int'(o_memAddr));
      wrDataQ.push_back(int'(o_memData));
      wrWrQ.push_back(int'(o_memWr));
      wrCycQ.push_back(cycle);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] expWord(input int i);
    return {eeprom[(2 * i) % EE_SIZE], eeprom[(2 * i + 1) % EE_SIZE]};
  endfunction

  task automatic fillImage(input logic [63:0] img);
    for (int i = 0; i < EE_SIZE; i++) eeprom[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) eeprom[i] = img[63 - 8 * i -: 8];
  endtask

  task automatic fillRandom();
    for (int i = 0; i < EE_SIZE; i++) eeprom[i] = 8'($urandom);
  endtask

  task automatic pulseStart();
    @(negedge i_clk);
    i_start = 1'b1;
    startCyc = cycle;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int n;
    n = 0;
    while (!o_done && n < LOAD_BUDGET) begin
      @(negedge i_clk);
      n++;
    end
    check({tag, "_doneInTime"}, 32'(n < LOAD_BUDGET), 32'd1);
    @(negedge i_clk);
    #1;
  endtask

  task automatic checkLoad(input string tag, input int wrBase, input int cmdBase, input int onesBase);
    logic [15:0] sum;
    sum = '0;
    check({tag, "_writeCount"}, 32'(wrAddrQ.size() - wrBase), 32'(LOAD_WORDS));
    for (int i = 0; i < LOAD_WORDS; i++) begin
      sum = sum + expWord(i);
      if (wrBase + i < wrAddrQ.size()) begin
        check($sformatf("%s_addr%0d", tag, i), 32'(wrAddrQ[wrBase + i]), 32'(i));
        check($sformatf("%s_data%0d", tag, i), 32'(wrDataQ[wrBase + i]), 32'(expWord(i)));
        check($sformatf("%s_wr%0d", tag, i), 32'(wrWrQ[wrBase + i]), 32'd1);
        check($sformatf("%s_lat%0d", tag, i), 32'(wrCycQ[wrBase + i] - startCyc),
              32'(FIRST_LAT + i * WORD_LAT));
      end
    end
    check({tag, "_cmdCount"}, 32'(cmdQ.size() - cmdBase), 32'd1);
    if (cmdQ.size() > cmdBase) check({tag, "_cmdFrame"}, 32'(cmdQ[cmdBase]), 32'h0003_0000);
    check({tag, "_mosiLowInData"}, 32'(dataMosiOnes - onesBase), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd1);
    check({tag, "_csn"}, 32'(o_spiCSn), 32'd1);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_sclk"}, 32'(o_spiCLK), 32'd0);
    check({tag, "_lastAddr"}, 32'(o_memAddr), 32'(LOAD_WORDS - 1));
`ifdef BOOT_LOADER_CHECKSUM_EN
    check({tag, "_csumOk"}, 32'(o_csumOk), 32'(sum == 16'h0000));
`endif
  endtask

  task automatic fullLoad(input string tag, input bit ignoredStart);
    int wrBase;
    int cmdBase;
    int onesBase;
    wrBase = wrAddrQ.size();
    cmdBase = cmdQ.size();
    onesBase = dataMosiOnes;
    pulseStart();
    check({tag, "_csnLowAfterStart"}, 32'(o_spiCSn), 32'd0);
    check({tag, "_busyAfterStart"}, 32'(o_busy), 32'd1);
    check({tag, "_doneClearedAfterStart"}, 32'(o_done), 32'd0);
    if (ignoredStart) begin
      repeat (FIRST_LAT + 20) @(negedge i_clk);
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      check({tag, "_busyAfterIgnored"}, 32'(o_busy), 32'd1);
    end
    waitDone(tag);
    checkLoad(tag, wrBase, cmdBase, onesBase);
  endtask

  initial begin
    int wrBase;
    fillRandom();

    // Reset idle: hold reset, release, then watch 100 cycles with no start.
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    check("rst_csnDuringReset", 32'(o_spiCSn), 32'd1);
    i_rst = 1'b0;
    check("rst_memAddr", 32'(o_memAddr), 32'd0);
    check("rst_memData", 32'(o_memData), 32'd0);
    check("rst_mosi", 32'(o_spiMOSI), 32'd0);
    check("rst_memWr", 32'(o_memWr), 32'd0);
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      check("idle_csn", 32'(o_spiCSn), 32'd1);
      check("idle_sclk", 32'(o_spiCLK), 32'd0);
      check("idle_memEn", 32'(o_memEn), 32'd0);
      check("idle_busy", 32'(o_busy), 32'd0);
      check("idle_done", 32'(o_done), 32'd0);
    end

    // Directed image.
    fillImage(64'h1234_ABCD_0001_FFFE);
    fullLoad("fixed", 1'b0);

    // Start pulse while busy must not disturb the load.
    fullLoad("ignoredStart", 1'b1);

    // Reset in the middle of word 2's data phase.
    fillRandom();
    wrBase = wrAddrQ.size();
    pulseStart();
    repeat (FIRST_LAT + WORD_LAT + 20) @(negedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    check("midRst_csnImmediate", 32'(o_spiCSn), 32'd1);
    check("midRst_sclk", 32'(o_spiCLK), 32'd0);
    check("midRst_busy", 32'(o_busy), 32'd0);
    check("midRst_memEn", 32'(o_memEn), 32'd0);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (400) @(negedge i_clk);
    check("midRst_writesBeforeReset", 32'(wrAddrQ.size() - wrBase), 32'd2);
    check("midRst_doneLow", 32'(o_done), 32'd0);
    check("midRst_csnIdle", 32'(o_spiCSn), 32'd1);
    fullLoad("reloadAfterRst", 1'b0);

    // Restarts from DONE with fresh random images.
    for (int k = 0; k < 3; k++) begin
      fillRandom();
      fullLoad($sformatf("restart%0d", k), 1'b0);
    end

`ifdef BOOT_LOADER_CHECKSUM_EN
    fillImage(64'h1234_EDCC_0000_0000);
    fullLoad("csumZero", 1'b0);
    check("csumZero_direct", 32'(o_csumOk), 32'd1);
    fillImage(64'h1234_EDCD_0000_0000);
    fullLoad("csumNonZero", 1'b0);
    check("csumNonZero_direct", 32'(o_csumOk), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
